// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, bit centre located from start edge.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote around each bit centre.
module uart_rx (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic [2:0] bps_set,
   output logic [7:0] data_o,
   output logic       rx_done,
   output logic       frame_err,
   output logic       rx_busy
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   localparam logic [12:0] DIV_9600 = 13'd5207;

   logic        rx_s1_q;
   logic        rx_s2_q;
   logic        rx_s3_q;
   state_t      state_q, state_d;
   logic [12:0] cnt_q, cnt_d;
   logic [12:0] div_q, div_d;
   logic [12:0] div_sel;
   logic [12:0] half;
   logic [3:0]  idx_q, idx_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        done_q, done_d;
   logic        ferr_q, ferr_d;
   logic        start_edge;
   logic        wrap;
   logic        sample_pt;
   logic        bit_val;

   // Baud divisor lookup for the requested rate
   always_comb begin
      div_sel = DIV_9600;
      unique case (bps_set)
         3'd1:    div_sel = 13'd2603;
         3'd2:    div_sel = 13'd1301;
         3'd3:    div_sel = 13'd867;
         3'd4:    div_sel = 13'd433;
         default: div_sel = DIV_9600;
      endcase
   end

   assign half       = div_q >> 1;
   assign start_edge = rx_s3_q & ~rx_s2_q;
   assign wrap       = (cnt_q == div_q);

`ifdef UART_RX_MAJORITY_EN
   logic maj_a_q;
   logic maj_b_q;

   // Capture the two samples preceding the decision point
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         maj_a_q <= 1'b1;
         maj_b_q <= 1'b1;
      end else begin
         if (cnt_q == half - 13'd1) maj_a_q <= rx_s2_q;
         if (cnt_q == half)         maj_b_q <= rx_s2_q;
      end
   end

   assign sample_pt = (cnt_q == half + 13'd1);
   assign bit_val   = (maj_a_q & maj_b_q) |
                      (maj_a_q & rx_s2_q) |
                      (maj_b_q & rx_s2_q);
`else
   assign sample_pt = (cnt_q == half);
   assign bit_val   = rx_s2_q;
`endif

   // Pin synchroniser plus one extra stage for falling-edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
         rx_s3_q <= 1'b1;
      end else begin
         rx_s1_q <= rx;
         rx_s2_q <= rx_s1_q;
         rx_s3_q <= rx_s2_q;
      end
   end

   // Next-state, bit timing and byte assembly
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      div_d   = div_q;
      shift_d = shift_q;
      data_d  = data_q;
      ferr_d  = ferr_q;
      done_d  = 1'b0;
      if (state_q != IDLE) begin
         cnt_d = wrap ? 13'd0 : cnt_q + 13'd1;
         if (wrap) idx_d = idx_q + 4'd1;
      end
      unique case (state_q)
         IDLE: begin
            if (start_edge) begin
               state_d = START;
               cnt_d   = 13'd0;
               idx_d   = 4'd0;
               div_d   = div_sel;
            end
         end
         START: begin
            if (sample_pt) state_d = bit_val ? IDLE : DATA;
         end
         DATA: begin
            if (sample_pt) begin
               shift_d = {bit_val, shift_q[7:1]};
               if (idx_q == 4'd8) state_d = STOP;
            end
         end
         STOP: begin
            if (sample_pt) begin
               data_d  = shift_q;
               ferr_d  = ~bit_val;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 13'd0;
         idx_q   <= 4'd0;
         div_q   <= DIV_9600;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         div_q   <= div_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
      end
   end

   assign data_o    = data_q;
   assign rx_done   = done_q;
   assign frame_err = ferr_q;
   assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx.
// Expected timing derived from the start edge driven by the bench.
`timescale 1ns/1ps
module tb_uart_rx;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic [2:0] bps_set;
   logic [7:0] data_o;
   logic       rx_done;
   logic       frame_err;
   logic       rx_busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int t_start = 0;
   int done_cnt = 0;
   int busy_cnt = 0;
   int done_cyc_q[$];
   logic [7:0] done_dat_q[$];

`ifdef UART_RX_MAJORITY_EN
   int maj_off = 1;
`else
   int maj_off = 0;
`endif

   uart_rx dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .bps_set   (bps_set),
      .data_o    (data_o),
      .rx_done   (rx_done),
      .frame_err (frame_err),
      .rx_busy   (rx_busy)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   // Record done strobes and busy cycles
   always @(negedge clk) begin
      if (rx_done) begin
         done_cnt = done_cnt + 1;
         done_cyc_q.push_back(cyc);
         done_dat_q.push_back(data_o);
      end
      if (rx_busy) busy_cnt = busy_cnt + 1;
   end

   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             input int d, input int ncyc, input bit spike);
      int p;
      int h;
      logic v;
      p = d + 1;
      h = d >> 1;
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < p; j++) begin
            if (i * p + j >= ncyc) return;
            if (i == 0) v = 1'b0;
            else if (i == 9) v = stop_bit;
            else v = b[i-1];
            if (spike && i >= 1 && i <= 8 && j == h + 1) v = ~v;
            @(posedge clk);
            #1;
            if (i == 0 && j == 0) t_start = cyc;
            rx = v;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      rx = 1'b1;
      bps_set = 3'd0;
      idle(3);
      n_cmp++;
      if (data_o !== 8'h00) begin
         n_err++;
         $display("FAIL reset_data: got %0h want 00", data_o);
      end
      n_cmp++;
      if (rx_done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_done: got %0b want 0", rx_done);
      end
      n_cmp++;
      if (frame_err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ferr: got %0b want 0", frame_err);
      end
      n_cmp++;
      if (rx_busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_busy: got %0b want 0", rx_busy);
      end
      rst_n = 1'b1;
      idle(5);
   endtask

   task automatic test_basic;
      int n0;
      int exp_cyc;
      bps_set = 3'd0;
      n0 = done_cnt;
      send_frame(8'hA5, 1'b1, 5207, 52080, 1'b0);
      rx = 1'b1;
      idle(2);
      exp_cyc = t_start + 4 + 9 * 5208 + 2603 + maj_off;
      n_cmp++;
      if (done_cnt - n0 !== 1) begin
         n_err++;
         $display("FAIL basic_count: got %0d want 1", done_cnt - n0);
      end
      n_cmp++;
      if (done_cyc_q[$] !== exp_cyc) begin
         n_err++;
         $display("FAIL basic_time: got %0d want %0d", done_cyc_q[$], exp_cyc);
      end
      n_cmp++;
      if (done_dat_q[$] !== 8'hA5) begin
         n_err++;
         $display("FAIL basic_data: got %0h want a5", done_dat_q[$]);
      end
      n_cmp++;
      if (frame_err !== 1'b0) begin
         n_err++;
         $display("FAIL basic_ferr: got %0b want 0", frame_err);
      end
      n_cmp++;
      if (rx_busy !== 1'b0) begin
         n_err++;
         $display("FAIL basic_busy: got %0b want 0", rx_busy);
      end
   endtask

   task automatic test_back_to_back;
      int n0;
      logic [7:0] exp_d [3];
      exp_d = '{8'h00, 8'hFF, 8'h55};
      bps_set = 3'd4;
      idle(5);
      n0 = done_cnt;
      for (int k = 0; k < 3; k++) send_frame(exp_d[k], 1'b1, 433, 4340, 1'b0);
      rx = 1'b1;
      idle(5);
      n_cmp++;
      if (done_cnt - n0 !== 3) begin
         n_err++;
         $display("FAIL b2b_count: got %0d want 3", done_cnt - n0);
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (done_dat_q[n0+k] !== exp_d[k]) begin
               n_err++;
               $display("FAIL b2b_data%0d: got %0h want %0h", k, done_dat_q[n0+k], exp_d[k]);
            end
         end
         for (int k = 1; k < 3; k++) begin
            n_cmp++;
            if (done_cyc_q[n0+k] - done_cyc_q[n0+k-1] !== 4340) begin
               n_err++;
               $display("FAIL b2b_gap%0d: got %0d want 4340", k,
                        done_cyc_q[n0+k] - done_cyc_q[n0+k-1]);
            end
         end
      end
   endtask

   task automatic test_frame_err;
      int n0;
      int b0;
      bps_set = 3'd4;
      n0 = done_cnt;
      send_frame(8'h3C, 1'b0, 433, 4340, 1'b0);
      n_cmp++;
      if (done_cnt - n0 !== 1) begin
         n_err++;
         $display("FAIL ferr_count: got %0d want 1", done_cnt - n0);
      end
      n_cmp++;
      if (data_o !== 8'h3C) begin
         n_err++;
         $display("FAIL ferr_data: got %0h want 3c", data_o);
      end
      n_cmp++;
      if (frame_err !== 1'b1) begin
         n_err++;
         $display("FAIL ferr_flag: got %0b want 1", frame_err);
      end
      b0 = busy_cnt;
      n0 = done_cnt;
      rx = 1'b0;
      idle(868);
      n_cmp++;
      if (busy_cnt - b0 !== 0 || done_cnt - n0 !== 0) begin
         n_err++;
         $display("FAIL break_idle: got busy %0d done %0d want 0 0",
                  busy_cnt - b0, done_cnt - n0);
      end
      rx = 1'b1;
      idle(5);
      send_frame(8'h01, 1'b1, 433, 4340, 1'b0);
      rx = 1'b1;
      n_cmp++;
      if (data_o !== 8'h01 || frame_err !== 1'b0) begin
         n_err++;
         $display("FAIL ferr_recover: got %0h/%0b want 01/0", data_o, frame_err);
      end
   endtask

   task automatic test_glitch;
      int n0;
      int b0;
      logic [7:0] prev;
      bps_set = 3'd4;
      idle(5);
      prev = data_o;
      n0 = done_cnt;
      b0 = busy_cnt;
      rx = 1'b0;
      idle(100);
      rx = 1'b1;
      idle(400);
      n_cmp++;
      if (busy_cnt - b0 !== 217 + maj_off) begin
         n_err++;
         $display("FAIL glitch_busy_len: got %0d want %0d", busy_cnt - b0, 217 + maj_off);
      end
      n_cmp++;
      if (done_cnt - n0 !== 0) begin
         n_err++;
         $display("FAIL glitch_done: got %0d want 0", done_cnt - n0);
      end
      n_cmp++;
      if (data_o !== prev || rx_busy !== 1'b0) begin
         n_err++;
         $display("FAIL glitch_hold: got %0h/%0b want %0h/0", data_o, rx_busy, prev);
      end
   endtask

   task automatic test_spike;
      logic [7:0] exp_d;
`ifdef UART_RX_MAJORITY_EN
      exp_d = 8'h81;
`else
      exp_d = 8'h7E;
`endif
      bps_set = 3'd4;
      idle(5);
      send_frame(8'h81, 1'b1, 433, 4340, 1'b1);
      rx = 1'b1;
      idle(5);
      n_cmp++;
      if (data_o !== exp_d) begin
         n_err++;
         $display("FAIL spike_data: got %0h want %0h", data_o, exp_d);
      end
   endtask

   task automatic test_reset_mid;
      int n0;
      bps_set = 3'd4;
      idle(5);
      n0 = done_cnt;
      send_frame(8'h5A, 1'b1, 433, 5 * 434 + 200, 1'b0);
      rx = 1'b1;
      rst_n = 1'b0;
      idle(3);
      n_cmp++;
      if (data_o !== 8'h00 || frame_err !== 1'b0 ||
          rx_busy !== 1'b0 || rx_done !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_state: got %0h/%0b/%0b/%0b want 00/0/0/0",
                  data_o, frame_err, rx_busy, rx_done);
      end
      rst_n = 1'b1;
      idle(5);
      send_frame(8'hC3, 1'b1, 433, 4340, 1'b0);
      rx = 1'b1;
      idle(5);
      n_cmp++;
      if (done_cnt - n0 !== 1) begin
         n_err++;
         $display("FAIL midreset_count: got %0d want 1", done_cnt - n0);
      end
      n_cmp++;
      if (data_o !== 8'hC3 || frame_err !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_data: got %0h/%0b want c3/0", data_o, frame_err);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      rx = 1'b1;
      bps_set = 3'd0;
      test_reset;
      test_basic;
      test_back_to_back;
      test_frame_err;
      test_glitch;
      test_spike;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: the receive-side companion to the team's `uart_tx`, sharing its baud divisor table and 8N1 frame format. Oversamples the `rx` pin with the system clock and locates each bit centre from the start-bit falling edge. Delivers each received byte on a parallel bus with a one-cycle `rx_done` strobe and a frame-error flag. Sits between the board RX pin and the byte consumer (loopback checker, command parser or FIFO).

## Interface
- No parameters. The divisor table is fixed and assumes a 50 MHz `clk`.
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx` in 1: serial line, idle high, asynchronous to `clk`.
- `bps_set` in 3: baud select.
  - 0: 9600, divisor 5207
  - 1: 19200, divisor 2603
  - 2: 38400, divisor 1301
  - 3: 57600, divisor 867
  - 4: 115200, divisor 433
  - 5–7: divisor 5207
- `data_o` out 8: last received byte, LSB received first.
- `rx_done` out 1: one-cycle pulse when a frame completes.
- `frame_err` out 1: stop bit of the last completed frame was sampled 0.
- `rx_busy` out 1: high from start-edge detection until the return to IDLE.

## Operation
- **Synchroniser and edge detect**
  - `rx` passes through a 2-flop synchroniser (`rx_s1`, `rx_s2`); a third flop `rx_s3` supports edge detection. All three reset to 1.
  - Start edge: `rx_s3==1 && rx_s2==0`. Detected in state IDLE only.
- **Divisor latch**
  - Divisor D is looked up from `bps_set` and latched in the edge cycle.
  - Changes to `bps_set` mid-frame are ignored until the next start edge.
  - Bit period P = D+1 clk. Half point H = D>>1.
- **Bit counter**
  - `bps_cnt` (13 bit) is cleared in the edge cycle.
  - Outside IDLE it counts 0..D and wraps to 0.
  - A bit index (4 bit) advances on each wrap.
- **State machine**
  - IDLE: `rx_busy`=0. On start edge go to START.
  - START: at the sample point, line 0 → DATA; line 1 (glitch) → IDLE with no `rx_done`.
  - DATA: at each sample point, shift the bit in LSB first. After the 8th bit go to STOP.
  - STOP: at the sample point:
    - register the shift register into `data_o`;
    - set `frame_err` to the inverse of the sampled bit;
    - pulse `rx_done`;
    - return to IDLE immediately, half a bit early, to allow resync on back-to-back frames.
- **Output holding**
  - `data_o` and `frame_err` hold until the next completed frame. They are updated even on a frame error.
- **Break / stuck-low line**
  - After a 0 stop bit, no new start edge is seen until `rx` goes high and then falls again.
- **Reset mid-frame**
  - Asynchronous return to IDLE; all state cleared.

## Timing
- Reset values:
  - `data_o`=8'h00, `rx_done`=0, `frame_err`=0, `rx_busy`=0.
  - `bps_cnt`=0, bit index=0, stored divisor=5207.
- Edge cycle E = the first cycle with `rx_s2`=0 while `rx_s3`=1. E falls 2–3 clk after the pin edge.
- Sample k (k=0 start, 1–8 data, 9 stop) is decided at cycle E+1+k·P+H without `UART_RX_MAJORITY_EN`, and one cycle later with it.
- `rx_done` is high for exactly one cycle, the cycle after the stop decision. `data_o` and `frame_err` are valid in that same cycle.
- `rx_busy` rises in E+1. It falls in the same cycle `rx_done` rises; on a start glitch it falls the cycle after the start decision.
- Minimum gap between frames: none. A start edge arriving right after the stop decision is accepted.

## Configuration
- `UART_RX_MAJORITY_EN`
  - Defined: each bit is the 2-of-3 majority of the synchronised line at `bps_cnt` = H-1, H and H+1. The decision is made at H+1, so all timing shifts +1 clk.
  - Undefined: single sample at `bps_cnt` == H, with no extra sample registers.

## Test plan
- `bps_set`=0, send 8'hA5 with a valid stop bit → one `rx_done` pulse about 9.5·5208 clk after the start edge; `data_o`=8'hA5, `frame_err`=0.
- `bps_set`=4, three back-to-back frames 8'h00, 8'hFF, 8'h55 with zero idle time → three `rx_done` pulses spaced 4340 clk apart, correct data each time.
- `bps_set`=4, 8'h3C sent with stop bit forced 0 → `rx_done` pulses, `data_o`=8'h3C, `frame_err`=1; next valid frame 8'h01 → `frame_err`=0.
- 100-clk low glitch on idle `rx` at `bps_set`=4 → `rx_busy` pulses, no `rx_done`, `data_o` unchanged.
- With `UART_RX_MAJORITY_EN` defined: 1-clk spike at the centre of each data bit of 8'h81 → `data_o`=8'h81. Without the macro, the same stimulus must corrupt the byte.
- `rst_n` asserted during data bit 4, released, then 8'hC3 sent → no `rx_done` for the aborted frame, all outputs at reset values, then `data_o`=8'hC3.
